// File: rtl/shift_seq_pkg.sv
// Shared encodings and defaults for the shift-register command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_seq_pkg;

    // Default geometry of the driven register and the shift-count field
    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 3;

    // Select-line encoding understood by the universal shift register
    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    // Sequencer phases: one load, N shifts, one completion cycle
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Map the command direction bit onto the register's shift select
    function automatic logic [1:0] shift_sel(input logic dir);
        return dir ? SEL_LEFT : SEL_RIGHT;
    endfunction

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter tracking the shift cycles left in a command.
// Latency: load/decrement visible one cycle later; terminal flag is combinational.
// Backpressure: none; counts whenever dec is asserted and the value is non-zero.
module shift_seq_counter
    import shift_seq_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] remaining,
    output logic             last
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Load has priority over decrement; never wrap below zero
    always_ff @(posedge CLK) begin
        if (Clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (dec && (remaining != '0)) begin
            remaining <= remaining - CNT_ONE;
        end
    end

    // Terminal flag: the current cycle is the final shift of the command
    always_comb begin
        last = (remaining == CNT_ONE);
    end

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for a universal shift register: load, N shifts, then a done cycle.
// Latency: accepted command loads on the next cycle; done pulses count+2 cycles after acceptance.
// Backpressure: cmd_ready is high only in IDLE; one command in flight. Option SHIFT_SEQ_ROTATE_EN.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic             abort,
    input  logic [WIDTH-1:0] sr_q,
    output logic [1:0]       sel_line,
    output logic [WIDTH-1:0] par_out,
    output logic             msb_in,
    output logic             lsb_in,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    seq_state_t       state;
    seq_state_t       state_nxt;

    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [CNT_W-1:0] count_q;
    logic             fill_q;
    logic             aborted_q;

    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] remaining;
    logic             cnt_last;
    logic             serial_bit;

    assign accept   = cmd_valid & cmd_ready;
    assign cnt_load = (state == ST_LOAD);
    assign cnt_dec  = (state == ST_SHIFT);

    // The register only samples par_out on a load, so it simply holds the captured word
    assign par_out = data_q;

    // State register; Clear drops any command in flight without a done pulse
    always_ff @(posedge CLK) begin
        if (Clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the command fields on the accepting handshake
    always_ff @(posedge CLK) begin
        if (Clear) begin
            data_q  <= '0;
            dir_q   <= 1'b0;
            count_q <= '0;
            fill_q  <= 1'b0;
        end else if (accept) begin
            data_q  <= cmd_data;
            dir_q   <= cmd_dir;
            count_q <= cmd_count;
            fill_q  <= cmd_fill;
        end
    end

    // Remember an early termination until it has been reported in DONE
    always_ff @(posedge CLK) begin
        if (Clear) begin
            aborted_q <= 1'b0;
        end else if ((state == ST_SHIFT) && abort) begin
            aborted_q <= 1'b1;
        end else if (state == ST_DONE) begin
            aborted_q <= 1'b0;
        end
    end

    // Remaining shifts; reloaded from the command in LOAD, counted down in SHIFT
    shift_seq_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .CLK       (CLK),
        .Clear     (Clear),
        .load      (cnt_load),
        .load_val  (count_q),
        .dec       (cnt_dec),
        .remaining (remaining),
        .last      (cnt_last)
    );

    // The remaining value itself is only needed for the terminal flag
    logic unused_remaining;
    assign unused_remaining = ^remaining;

    // Register feedback is only consumed in rotate mode
    logic unused_sr_q;
    assign unused_sr_q = ^sr_q;

`ifdef SHIFT_SEQ_ROTATE_EN
    // Rotate mode: a set fill bit recirculates the bit falling off the far end
    always_comb begin
        serial_bit = 1'b0;
        if (fill_q) begin
            serial_bit = dir_q ? sr_q[WIDTH-1] : sr_q[0];
        end
    end
`else
    // Literal fill: the captured fill bit is shifted in on every cycle
    always_comb begin
        serial_bit = fill_q;
    end
`endif

    // Next-state and Moore output decode from the registered state and command
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        sel_line  = SEL_HOLD;
        msb_in    = 1'b0;
        lsb_in    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        aborted   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sel_line  = SEL_LOAD;
                state_nxt = (count_q == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                sel_line = shift_sel(dir_q);
                if (dir_q) begin
                    lsb_in = serial_bit;
                end else begin
                    msb_in = serial_bit;
                end
                // An abort still lets this cycle's shift happen
                if (abort || cnt_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                aborted   = aborted_q;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural universal shift register model.
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_sequencer;

    logic       CLK;
    logic       Clear;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic       cmd_dir;
    logic [2:0] cmd_count;
    logic       cmd_fill;
    logic       abort;
    logic [3:0] sr_q;
    logic [1:0] sel_line;
    logic [3:0] par_out;
    logic       msb_in;
    logic       lsb_in;
    logic       busy;
    logic       done;
    logic       aborted;

    logic [3:0] ref_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] data;
        logic       dir;
        logic [2:0] count;
        logic       fill;
        int         abort_at;
        logic [3:0] exp_q;
        logic       exp_ab;
    } vec_t;

    vec_t vecs[6];

    shift_sequencer #(
        .WIDTH (4),
        .CNT_W (3)
    ) dut (
        .CLK       (CLK),
        .Clear     (Clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_count (cmd_count),
        .cmd_fill  (cmd_fill),
        .abort     (abort),
        .sr_q      (sr_q),
        .sel_line  (sel_line),
        .par_out   (par_out),
        .msb_in    (msb_in),
        .lsb_in    (lsb_in),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference universal shift register driven by the sequencer
    always @(posedge CLK) begin
        case (sel_line)
            2'b11:   ref_q <= par_out;
            2'b01:   ref_q <= {msb_in, ref_q[3:1]};
            2'b10:   ref_q <= {ref_q[2:0], lsb_in};
            default: ref_q <= ref_q;
        endcase
    end
    assign sr_q = ref_q;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one command from IDLE and follow it cycle by cycle to the next IDLE
    task automatic run_cmd(input vec_t v);
        int   n_shift;
        logic exp_ser;
        n_shift = int'(v.count);
        if ((v.abort_at != 0) && (v.abort_at < n_shift)) n_shift = v.abort_at;

        check("idle_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_data  = v.data;
        cmd_dir   = v.dir;
        cmd_count = v.count;
        cmd_fill  = v.fill;
        tick();
        cmd_valid = 1'b0;
        check("load_sel", 32'(sel_line), 3);
        check("load_par", 32'(par_out), 32'(v.data));
        check("load_busy", 32'(busy), 1);
        check("load_ready", 32'(cmd_ready), 0);
        check("load_serial", 32'({msb_in, lsb_in}), 0);

        for (int i = 1; i <= n_shift; i++) begin
            tick();
`ifdef SHIFT_SEQ_ROTATE_EN
            exp_ser = v.fill ? (v.dir ? ref_q[3] : ref_q[0]) : 1'b0;
`else
            exp_ser = v.fill;
`endif
            check("shift_sel", 32'(sel_line), v.dir ? 2 : 1);
            check("shift_msb", 32'(msb_in), v.dir ? 0 : 32'(exp_ser));
            check("shift_lsb", 32'(lsb_in), v.dir ? 32'(exp_ser) : 0);
            check("shift_done", 32'(done), 0);
            check("shift_ready", 32'(cmd_ready), 0);
            abort = (i == v.abort_at);
        end

        tick();
        abort = 1'b0;
        check("done_sel", 32'(sel_line), 0);
        check("done_pulse", 32'(done), 1);
        check("done_aborted", 32'(aborted), 32'(v.exp_ab));
        check("done_busy", 32'(busy), 1);
        check("done_serial", 32'({msb_in, lsb_in}), 0);

        tick();
        check("end_busy", 32'(busy), 0);
        check("end_done", 32'(done), 0);
        check("end_ready", 32'(cmd_ready), 1);
        check("end_reg", 32'(ref_q), 32'(v.exp_q));
    endtask

    initial begin
`ifdef SHIFT_SEQ_ROTATE_EN
        vecs[0] = '{4'b1010, 1'b0, 3'd3, 1'b1, 0, 4'b0101, 1'b0};
`else
        vecs[0] = '{4'b1010, 1'b0, 3'd3, 1'b1, 0, 4'b1111, 1'b0};
`endif
        vecs[1] = '{4'b0111, 1'b1, 3'd2, 1'b0, 0, 4'b1100, 1'b0};
        vecs[2] = '{4'b0101, 1'b0, 3'd0, 1'b0, 0, 4'b0101, 1'b0};
        vecs[3] = '{4'b1000, 1'b1, 3'd1, 1'b1, 0, 4'b0001, 1'b0};
        vecs[4] = '{4'b0001, 1'b0, 3'd7, 1'b0, 0, 4'b0000, 1'b0};
        vecs[5] = '{4'b1010, 1'b0, 3'd5, 1'b0, 2, 4'b0010, 1'b1};

        Clear     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 4'b0000;
        cmd_dir   = 1'b0;
        cmd_count = 3'd0;
        cmd_fill  = 1'b0;
        abort     = 1'b0;
        repeat (3) tick();
        Clear = 1'b0;
        check("rst_sel", 32'(sel_line), 0);
        check("rst_par", 32'(par_out), 0);
        check("rst_serial", 32'({msb_in, lsb_in}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'({done, aborted}), 0);
        check("rst_ready", 32'(cmd_ready), 1);

        for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

        // Abort while idle must not leave anything behind
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 0);
        run_cmd(vecs[3]);

        // Back-to-back: valid held high, second command taken in the first IDLE cycle
        cmd_valid = 1'b1;
        cmd_data  = 4'b1001;
        cmd_dir   = 1'b0;
        cmd_count = 3'd1;
        cmd_fill  = 1'b0;
        tick();
        check("b2b_a_load", 32'(sel_line), 3);
        check("b2b_a_ready_load", 32'(cmd_ready), 0);
        cmd_data  = 4'b0011;
        cmd_dir   = 1'b1;
        cmd_count = 3'd2;
        tick();
        check("b2b_a_shift", 32'(sel_line), 1);
        check("b2b_a_ready_shift", 32'(cmd_ready), 0);
        tick();
        check("b2b_a_done", 32'(done), 1);
        check("b2b_a_ready_done", 32'(cmd_ready), 0);
        tick();
        check("b2b_idle_ready", 32'(cmd_ready), 1);
        check("b2b_idle_busy", 32'(busy), 0);
        check("b2b_a_reg", 32'(ref_q), 32'(4'b0100));
        tick();
        cmd_valid = 1'b0;
        check("b2b_b_load", 32'(sel_line), 3);
        check("b2b_b_par", 32'(par_out), 32'(4'b0011));
        tick();
        check("b2b_b_shift1", 32'(sel_line), 2);
        tick();
        check("b2b_b_shift2", 32'(sel_line), 2);
        tick();
        check("b2b_b_done", 32'(done), 1);
        tick();
        check("b2b_b_reg", 32'(ref_q), 32'(4'b1100));
        check("b2b_b_idle", 32'(busy), 0);

        // Clear in the third shift cycle kills the command without a done pulse
        cmd_valid = 1'b1;
        cmd_data  = 4'b1111;
        cmd_dir   = 1'b0;
        cmd_count = 3'd5;
        cmd_fill  = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        check("clr_in_shift3", 32'(sel_line), 1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("clr_sel", 32'(sel_line), 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_par", 32'(par_out), 0);
        check("clr_ready", 32'(cmd_ready), 1);
        for (int i = 0; i < 6; i++) begin
            check("clr_no_done", 32'({done, aborted, busy}), 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
